// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - op encodings as presented on op_i
//   - controller FSM state encoding (2 bits)
//   - default operand width
package muldiv_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Datapath for the iterative multiply/divide unit.
// Holds the 2*DATA_W accumulator (hi half = partial product / remainder,
// lo half = multiplier / quotient), the second-operand magnitude and the
// sign bookkeeping. A single DATA_W+1 bit adder/subtractor is shared by
// shift-add multiply and restoring shift-subtract divide.
// Ports:
//   clk_i, rst_i      clock, sync active-high reset (result registers only)
//   load_i            capture op_i/data1_i/data2_i, start a new operation
//   step_i            perform one iteration
//   fix_i             apply sign/div-by-zero fixup and update hi_o/lo_o/dz_o
//   op_i              operation code (muldiv_pkg::op_e encoding)
//   data1_i, data2_i  multiplicand/dividend, multiplier/divisor
//   hi_o, lo_o, dz_o  held result registers
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              fix_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  output logic              dz_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   opb;
  logic [DATA_W-1:0]   d1_raw;
  logic                is_div;
  logic                neg_q;
  logic                neg_r;
  logic                dz_q;

  logic                sgn_op;
  logic                a_neg;
  logic                b_neg;
  logic [DATA_W:0]     add_a;
  logic [DATA_W:0]     add_b;
  logic [DATA_W:0]     add_res;
  logic [DATA_W:0]     mul_hi;
  logic [2*DATA_W-1:0] acc_step;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   q_fix;
  logic [DATA_W-1:0]   r_fix;

  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic n);
    logic signed [DATA_W-1:0] vs;
    vs = v;
    return n ? -vs : vs;
  endfunction

  assign sgn_op = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign a_neg  = sgn_op & data1_i[DATA_W-1];
  assign b_neg  = sgn_op & data2_i[DATA_W-1];

  // Divide compares against the remainder shifted left one place; multiply
  // adds to the unshifted high half. The remainder never exceeds twice the
  // divisor, so the DATA_W+1 bit difference carries its sign in the MSB.
  always_comb begin
    add_a   = is_div ? acc[2*DATA_W-1:DATA_W-1] : {1'b0, acc[2*DATA_W-1:DATA_W]};
    add_b   = {1'b0, opb};
    add_res = is_div ? (add_a - add_b) : (add_a + add_b);
    mul_hi  = acc[0] ? add_res : {1'b0, acc[2*DATA_W-1:DATA_W]};
    if (is_div) begin
      acc_step = {(add_res[DATA_W] ? acc[2*DATA_W-2:DATA_W-1] : add_res[DATA_W-1:0]),
                  acc[DATA_W-2:0], ~add_res[DATA_W]};
    end else begin
      acc_step = {mul_hi, acc[DATA_W-1:1]};
    end
  end

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    q_fix    = neg_if(acc[DATA_W-1:0], neg_q);
    r_fix    = neg_if(acc[2*DATA_W-1:DATA_W], neg_r);
  end

  // Operand capture / iteration
  always_ff @(posedge clk_i) begin
    if (load_i) begin
      acc    <= {{DATA_W{1'b0}}, neg_if(data1_i, a_neg)};
      opb    <= neg_if(data2_i, b_neg);
      d1_raw <= data1_i;
      is_div <= op_i[1];
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      dz_q   <= op_i[1] & (data2_i == '0);
    end else if (step_i) begin
      acc <= acc_step;
    end
  end

  // Result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_o <= '0;
      lo_o <= '0;
      dz_o <= 1'b0;
    end else if (fix_i) begin
      if (is_div && dz_q) begin
        hi_o <= d1_raw;
        lo_o <= '1;
        dz_o <= 1'b1;
      end else if (is_div) begin
        hi_o <= r_fix;
        lo_o <= q_fix;
        dz_o <= 1'b0;
      end else begin
        hi_o <= prod_fix[2*DATA_W-1:DATA_W];
        lo_o <= prod_fix[DATA_W-1:0];
        dz_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide controller (MULT, MULTU, DIV, DIVU).
// Sequences IDLE -> RUN (DATA_W iterations) -> FIX -> DONE and drives the
// load/step/fix strobes of muldiv_datapath.
// Ports:
//   clk_i, rst_i      clock, sync active-high reset
//   start_i           request, accepted in IDLE or DONE only
//   op_i              00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   data1_i, data2_i  multiplicand/dividend, multiplier/divisor
//   busy_o            high in RUN and FIX
//   done_o            one-cycle pulse when hi_o/lo_o hold a fresh result
//   dz_o              divide-by-zero flag of the last result
//   hi_o, lo_o        product high/low, or remainder/quotient
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              dz_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             load;
  logic             step;
  logic             fix;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == ST_RUN) ? cnt_q + 1'b1 : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        busy_o = 1'b1;
        step   = 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        busy_o  = 1'b1;
        fix     = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_o = 1'b1;
        if (start_i) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  muldiv_datapath #(
    .DATA_W(DATA_W)
  ) u_dp (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (load),
    .step_i (step),
    .fix_i  (fix),
    .op_i   (op_i),
    .data1_i(data1_i),
    .data2_i(data2_i),
    .dz_o   (dz_o),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes hand-computed results
// (with the cycle at which done_o must appear); a monitor pops them on done_o.
module tb_muldiv_ctrl;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        busy_o;
  logic        done_o;
  logic        dz_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  muldiv_ctrl dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .start_i(start_i),
    .op_i   (op_i),
    .data1_i(data1_i),
    .data2_i(data2_i),
    .busy_o (busy_o),
    .done_o (done_o),
    .dz_o   (dz_o),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare every done_o pulse against the oldest expectation.
  always @(negedge clk) begin
    if (done_o === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done_o=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        e = sbq.pop_front();
        check("hi_o", 64'(hi_o), 64'(e.hi));
        check("lo_o", 64'(lo_o), 64'(e.lo));
        check("dz_o", 64'(dz_o), 64'(e.dz));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic drive(input logic [1:0] op, input logic [31:0] d1, input logic [31:0] d2);
    op_i    = op;
    data1_i = d1;
    data2_i = d2;
    start_i = 1'b1;
  endtask

  // Called at a negedge; the start is sampled at the following posedge and
  // done_o must be seen at the negedge 34 cycles from now.
  task automatic drive_start(input logic [1:0] op, input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    exp_t x;
    drive(op, d1, d2);
    x.hi  = ehi;
    x.lo  = elo;
    x.dz  = edz;
    x.cyc = cyc + 34;
    sbq.push_back(x);
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    @(negedge clk);
    drive_start(op, d1, d2, ehi, elo, edz);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got %0d pending results, expected 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    op_i    = 2'b00;
    data1_i = '0;
    data2_i = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_dz",   64'(dz_o),   64'd0);
    check("rst_hi",   64'(hi_o),   64'd0);
    check("rst_lo",   64'(lo_o),   64'd0);
    rst_i = 1'b0;

    // MULTU with busy profile: high for cycles 1..33, low in the done cycle
    start_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    for (int k = 1; k <= 34; k++) begin
      check($sformatf("busy_k%0d", k), 64'(busy_o), 64'(k <= 33));
      if (k < 34) @(negedge clk);
    end
    wait_idle();

    start_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    wait_idle();
    start_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    wait_idle();
    start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    wait_idle();
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
    wait_idle();
    start_op(2'b11, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0);
    wait_idle();
    start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    wait_idle();

    // Divide by zero, then a normal divide; the dz result holds during RUN
    start_op(2'b10, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1);
    wait_idle();
    start_op(2'b10, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0);
    check("hold_dz", 64'(dz_o), 64'd1);
    check("hold_lo", 64'(lo_o), 64'hFFFF_FFFF);
    check("hold_hi", 64'(hi_o), 64'h0000_0007);
    wait_idle();
    start_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    wait_idle();

    // start_i during RUN at cycles 5 and 20 with other operands is ignored
    start_op(2'b10, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0);
    repeat (4) @(negedge clk);
    drive(2'b00, 32'h0000_0003, 32'h0000_0003);
    @(negedge clk);
    start_i = 1'b0;
    repeat (14) @(negedge clk);
    drive(2'b01, 32'h0000_0009, 32'h0000_0009);
    @(negedge clk);
    start_i = 1'b0;
    data1_i = 32'h1234_5678;
    wait_idle();

    // start_i in the DONE cycle chains straight into a new RUN
    start_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    repeat (33) @(negedge clk);
    drive_start(2'b10, 32'h0000_03E8, 32'h0000_000A, 32'h0000_0000, 32'h0000_0064, 1'b0);
    @(negedge clk);
    start_i = 1'b0;
    check("b2b_busy", 64'(busy_o), 64'd1);
    wait_idle();

    // Reset at RUN cycle 10 aborts without a done pulse
    @(negedge clk);
    drive(2'b00, 32'h0000_0005, 32'h0000_0006);
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_done", 64'(done_o), 64'd0);
    check("abort_hi",   64'(hi_o),   64'd0);
    check("abort_lo",   64'(lo_o),   64'd0);
    check("abort_dz",   64'(dz_o),   64'd0);
    repeat (40) @(negedge clk);

    start_op(2'b00, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
